dparm_sdp: RTL and testbench



---
 rtl/dparm_sdp_pkg.sv | 15 +
 rtl/dparm_sdp_outreg.sv | 27 ++
 rtl/dparm_sdp.sv | 68 ++++++
 tb/tb_dparm_sdp.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dparm_sdp_pkg.sv
// rtl/dparm_sdp_pkg.sv - shared constants for the dparm_sdp simple dual-port RAM
// Holds the default geometry and the read latency seen at q.
// Optional feature: DPARM_SDP_OUTREG_EN adds a second output register (latency 2).
package dparm_sdp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

`ifdef DPARM_SDP_OUTREG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/dparm_sdp_outreg.sv
// rtl/dparm_sdp_outreg.sv - DATA_W pipeline register with synchronous reset value
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset, loads RESET_Q
//   d      in   DATA_W data in
//   q      out  DATA_W registered data out
module dparm_sdp_outreg
    import dparm_sdp_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_Q = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_Q;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dparm_sdp.sv
// rtl/dparm_sdp.sv - single-clock simple dual-port RAM, one write and one read port
// Optional feature macro: DPARM_SDP_OUTREG_EN (second output register, latency 2).
// Ports:
//   clock      in   sole clock, all state updates on the rising edge
//   reset      in   synchronous active-high; clears the read pipeline only
//   data       in   DATA_W write data
//   rdaddress  in   ADDR_W read address, sampled every edge
//   wraddress  in   ADDR_W write address, sampled when wren=1
//   wren       in   write enable
//   q          out  DATA_W read data, RD_LATENCY edges after rdaddress
module dparm_sdp
    import dparm_sdp_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] RESET_Q = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] stage1_q;

    // Write port is deliberately not gated by reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
    end

    // The read register samples the array before this edge's write lands,
    // which gives old-data behaviour on a same-address collision.
    assign rd_word = mem[rdaddress];

    dparm_sdp_outreg #(
        .DATA_W  (DATA_W),
        .RESET_Q (RESET_Q)
    ) u_rdreg (
        .clock (clock),
        .reset (reset),
        .d     (rd_word),
        .q     (stage1_q)
    );

`ifdef DPARM_SDP_OUTREG_EN
    dparm_sdp_outreg #(
        .DATA_W  (DATA_W),
        .RESET_Q (RESET_Q)
    ) u_outreg (
        .clock (clock),
        .reset (reset),
        .d     (stage1_q),
        .q     (q)
    );
`else
    assign q = stage1_q;
`endif

endmodule

// File: tb/tb_dparm_sdp.sv
// tb/tb_dparm_sdp.sv - scoreboard bench for dparm_sdp (either read latency)
module tb_dparm_sdp;
    import dparm_sdp_pkg::*;

    localparam int                DATA_W  = 8;
    localparam int                ADDR_W  = 8;
    localparam logic [DATA_W-1:0] RESET_Q = '0;
    localparam int                LAT     = RD_LATENCY;

    logic              clock;
    logic              reset;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] rdaddress;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic [DATA_W-1:0] q;

    dparm_sdp #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RESET_Q (RESET_Q)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference memory plus a written-flag so never-written words are not checked.
    logic [DATA_W-1:0] model  [2**ADDR_W];
    bit                mvalid [2**ADDR_W];

    logic [DATA_W-1:0] exp_q [$];
    bit                ok_q  [$];
    string             tag_q [$];

    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_tag  = "init";

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; expectation is taken from the model before the
    // write is applied, matching read-old-data on collision.
    task automatic cyc(input bit rst, input bit we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] ra);
        @(negedge clock);
        reset     = rst;
        wren      = we;
        wraddress = wa;
        data      = d;
        rdaddress = ra;
        if (rst) begin
            exp_q.delete();
            ok_q.delete();
            tag_q.delete();
            for (int k = 0; k < LAT; k++) begin
                exp_q.push_back(RESET_Q);
                ok_q.push_back(1'b1);
                tag_q.push_back({cur_tag, "_rstq"});
            end
        end else begin
            exp_q.push_back(model[ra]);
            ok_q.push_back(mvalid[ra]);
            tag_q.push_back(cur_tag);
        end
        if (we) begin
            model[wa]  = d;
            mvalid[wa] = 1'b1;
        end
    endtask

    // Monitor: one pipeline slot leaves the scoreboard per rising edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() >= LAT) begin
            logic [DATA_W-1:0] e;
            bit                v;
            string             t;
            e = exp_q.pop_front();
            v = ok_q.pop_front();
            t = tag_q.pop_front();
            if (v) check_eq(t, q, e);
        end
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mvalid[i] = 1'b0;
        reset     = 1'b1;
        wren      = 1'b0;
        data      = '0;
        rdaddress = '0;
        wraddress = '0;

        // Reset held 3 cycles; a write to addr 0 during reset must still land.
        cur_tag = "reset";
        cyc(1, 1, 8'd0, 8'h3C, 8'd0);
        cyc(1, 0, 8'd0, 8'h00, 8'd0);
        cyc(1, 0, 8'd0, 8'h00, 8'd0);
        cur_tag = "rst_release";
        cyc(0, 0, 8'd0, 8'h00, 8'd0);

        cur_tag = "fill";
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 8'(255 - i), 8'd0);
        cur_tag = "readback";
        for (int i = 0; i < 16; i++) cyc(0, 0, 8'd0, 8'h00, 8'(i));

        cur_tag = "preload5";
        cyc(0, 1, 8'd5, 8'h11, 8'd1);
        cur_tag = "rdw_old";
        cyc(0, 1, 8'd5, 8'hAA, 8'd5);
        cur_tag = "rdw_new";
        cyc(0, 0, 8'd0, 8'h00, 8'd5);

        cur_tag = "wren_gate";
        cyc(0, 0, 8'd3, 8'h55, 8'd3);
        cyc(0, 0, 8'd3, 8'h55, 8'd3);

        cur_tag = "extremes";
        cyc(0, 1, 8'd128, 8'h80, 8'd2);
        cyc(0, 1, 8'd0,   8'h00, 8'd128);
        cyc(0, 1, 8'd255, 8'hFF, 8'd128);
        cyc(0, 0, 8'd0,   8'h00, 8'd0);
        cyc(0, 0, 8'd0,   8'h00, 8'd255);
        cyc(0, 0, 8'd0,   8'h00, 8'd128);

        cur_tag = "random";
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                8'($urandom_range(0, 31)));
        end

        // Reset mid-stream with valid data in flight.
        cur_tag = "pre_rst";
        cyc(0, 0, 8'd0, 8'h00, 8'd255);
        cyc(0, 0, 8'd0, 8'h00, 8'd255);
        cur_tag = "mid_rst";
        cyc(1, 0, 8'd0, 8'h00, 8'd255);
        cur_tag = "post_rst";
        cyc(0, 0, 8'd0, 8'h00, 8'd255);
        cyc(0, 0, 8'd0, 8'h00, 8'd128);

        cur_tag = "drain";
        for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 8'd0, 8'h00, 8'd255);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
